// File: rtl/dmem_dump_reader_if.sv
// Bundles the dump-reader control, data-memory read port and output stream.
// master is the reader's view; slave is the view of whatever surrounds it.
interface dmem_dump_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, word_count, mem_rd_data, out_ready,
        output mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done
    );

    modport slave (
        output start, base_addr, word_count, mem_rd_data, out_ready,
        input  mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done
    );
endinterface

// File: rtl/dmem_dump_reader.sv
// Streams a contiguous range of data-memory words, with their addresses, onto a
// valid/ready stream, one word per ISSUE/CAPTURE/PRESENT round trip.
module dmem_dump_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk_CPU,
    input  logic                rst,
    dmem_dump_reader_if.master  bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, DONE} state_t;

    localparam logic [ADDR_W:0]   REM_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;

    // Outputs are registered, so each is set on the transition into the state that owns it.
    always_ff @(posedge clk_CPU) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.word_count != '0) begin
                            cur_addr  <= bus.base_addr;
                            remaining <= bus.word_count;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= bus.base_addr;
                            busy      <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    mem_rd_en <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    out_data  <= bus.mem_rd_data;
                    out_addr  <= cur_addr;
                    out_last  <= (remaining == REM_ONE);
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - REM_ONE;
                        cur_addr  <= cur_addr + ADDR_ONE;
                        if (remaining != REM_ONE) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= cur_addr + ADDR_ONE;
                            state     <= ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en = mem_rd_en;
    assign bus.mem_addr  = mem_addr;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_addr  = out_addr;
    assign bus.out_last  = out_last;
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule
